// File: rtl/multicycle_sequencer.sv
// Multicycle instruction sequencer: walks each instruction through its own
// IF/ID/EX/MEM/WB stage path, publishes the microcode (class, stage) index,
// flags retirement and counts retired instructions. Stops in HALT on an
// unsupported encoding until reset.
module multicycle_sequencer #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic [31:0]          instr,
    input  logic                 imem_ready,
    input  logic                 dmem_ready,
    output logic [4:0]           inst,
    output logic [2:0]           stage,
    output logic                 retire,
    output logic                 halt,
    output logic [CNT_WIDTH-1:0] retired_count
);

    // Microcode classes that steer the stage path
    localparam logic [4:0] C_LW      = 5'd20;
    localparam logic [4:0] C_SW      = 5'd21;
    localparam logic [4:0] C_BR_A    = 5'd24;
    localparam logic [4:0] C_BR_B    = 5'd25;
    localparam logic [4:0] C_LUI     = 5'd26;
    localparam logic [4:0] C_AUIPC   = 5'd27;
    localparam logic [4:0] C_ILLEGAL = 5'd28;

    // Encodings 0..4 double as the visible stage index; HALT shows stage 0.
    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5
    } state_e;

    state_e               state_q, state_d;
    logic [4:0]           cls_q, cls_d;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic [4:0]           dec_cls;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       alt;
    logic       unused_instr_bits;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign alt    = instr[30];
    // Only opcode, funct3 and bit 30 select the class.
    assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

    // Combinational class decode of the fetched word
    always_comb begin
        dec_cls = C_ILLEGAL;
        case (opcode)
            7'b0110011: begin
                case (funct3)
                    3'b000:  dec_cls = alt ? 5'd1 : 5'd0;
                    3'b010:  dec_cls = 5'd2;
                    3'b011:  dec_cls = 5'd3;
                    3'b100:  dec_cls = 5'd4;
                    3'b110:  dec_cls = 5'd5;
                    3'b111:  dec_cls = 5'd6;
                    3'b001:  dec_cls = 5'd7;
                    default: dec_cls = alt ? 5'd9 : 5'd8;
                endcase
            end
            7'b0010011: begin
                case (funct3)
                    3'b000:  dec_cls = 5'd10;
                    3'b010:  dec_cls = 5'd12;
                    3'b011:  dec_cls = 5'd13;
                    3'b100:  dec_cls = 5'd14;
                    3'b110:  dec_cls = 5'd15;
                    3'b111:  dec_cls = 5'd16;
                    // A shift-left with bit 30 set has no defined meaning.
                    3'b001:  dec_cls = alt ? C_ILLEGAL : 5'd17;
                    default: dec_cls = alt ? 5'd19 : 5'd18;
                endcase
            end
            7'b0000011: dec_cls = (funct3 == 3'b010) ? C_LW : C_ILLEGAL;
            7'b0100011: dec_cls = (funct3 == 3'b010) ? C_SW : C_ILLEGAL;
            7'b1100111: dec_cls = 5'd22;
            7'b1101111: dec_cls = 5'd23;
            7'b1100011: begin
                case (funct3)
                    3'b000, 3'b001, 3'b100, 3'b101: dec_cls = C_BR_A;
                    3'b110, 3'b111:                 dec_cls = C_BR_B;
                    default:                        dec_cls = C_ILLEGAL;
                endcase
            end
            7'b0110111: dec_cls = C_LUI;
            7'b0010111: dec_cls = C_AUIPC;
            default:    dec_cls = C_ILLEGAL;
        endcase
    end

    // Next-state and output logic for the stage walker
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        inst    = cls_q;
        stage   = 3'd0;
        retire  = 1'b0;
        halt    = 1'b0;
        case (state_q)
            S_IF: begin
                // Class follows instr live until the fetch completes.
                inst = dec_cls;
                if (imem_ready) begin
                    cls_d = dec_cls;
                    case (dec_cls)
                        C_ILLEGAL: state_d = S_HALT;
                        C_LUI:     state_d = S_WB;
                        C_AUIPC:   state_d = S_EX;
                        default:   state_d = S_ID;
                    endcase
                end
            end
            S_ID: begin
                stage   = 3'd1;
                state_d = S_EX;
            end
            S_EX: begin
                stage = 3'd2;
                if (cls_q == C_LW || cls_q == C_SW) begin
                    state_d = S_MEM;
                end else if (cls_q == C_BR_A || cls_q == C_BR_B) begin
                    state_d = S_IF;
                    retire  = 1'b1;
                end else begin
                    state_d = S_WB;
                end
            end
            S_MEM: begin
                stage = 3'd3;
                if (dmem_ready) begin
                    if (cls_q == C_SW) begin
                        state_d = S_IF;
                        retire  = 1'b1;
                    end else begin
                        state_d = S_WB;
                    end
                end
            end
            S_WB: begin
                stage   = 3'd4;
                state_d = S_IF;
                retire  = 1'b1;
            end
            S_HALT: begin
                inst = C_ILLEGAL;
                halt = 1'b1;
            end
            default: begin
                // Unused encodings fall back to fetch on the next edge.
                state_d = S_IF;
            end
        endcase
    end

    // Stage/class registers with asynchronous active-low reset
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= S_IF;
            cls_q   <= 5'd0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
        end
    end

    // Retired-instruction counter, wraps naturally at its width
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            cnt_q <= '0;
        end else if (retire) begin
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

    assign retired_count = cnt_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Bench for multicycle_sequencer: directed instruction sequences with
// hand-written stage paths; a queue of expected per-cycle outputs is
// consumed by an independent monitor. A second 4-bit-counter instance
// runs on the same stimulus to exercise counter wrap.
module tb_multicycle_sequencer;

  localparam int W = 42; // {halt, retire, stage[2:0], inst[4:0], count[31:0]}

  logic        CLK;
  logic        RSTn;
  logic [31:0] instr;
  logic        imem_ready;
  logic        dmem_ready;

  logic [4:0]  inst;
  logic [2:0]  stage;
  logic        retire;
  logic        halt;
  logic [31:0] retired_count;

  logic [4:0]  inst4;
  logic [2:0]  stage4;
  logic        retire4;
  logic        halt4;
  logic [3:0]  retired_count4;

  logic [W-1:0] exp_q[$];
  logic [31:0]  exp_cnt;
  logic         async_tick;
  int           checks;
  int           errors;
  int           samples;

  multicycle_sequencer dut (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .instr        (instr),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .inst         (inst),
    .stage        (stage),
    .retire       (retire),
    .halt         (halt),
    .retired_count(retired_count)
  );

  multicycle_sequencer #(.CNT_WIDTH(4)) dut_w4 (
    .CLK          (CLK),
    .RSTn         (RSTn),
    .instr        (instr),
    .imem_ready   (imem_ready),
    .dmem_ready   (dmem_ready),
    .inst         (inst4),
    .stage        (stage4),
    .retire       (retire4),
    .halt         (halt4),
    .retired_count(retired_count4)
  );

  // ---------------- clock ----------------
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    logic [13:0]  e4;
    logic [13:0]  a4;
    forever begin
      @(negedge CLK or async_tick);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        a  = {halt, retire, stage, inst, retired_count};
        e4 = {e[41:32], e[3:0]};
        a4 = {halt4, retire4, stage4, inst4, retired_count4};
        samples++;
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs sample %0d: got halt=%b retire=%b stage=%0d inst=%0d count=%0d, want halt=%b retire=%b stage=%0d inst=%0d count=%0d",
                   samples, a[41], a[40], a[39:37], a[36:32], a[31:0],
                   e[41], e[40], e[39:37], e[36:32], e[31:0]);
        end
        checks++;
        if (a4 !== e4) begin
          errors++;
          $display("FAIL w4_outputs sample %0d: got %h want %h", samples, a4, e4);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock cycle: drive inputs, record expected outputs for this cycle.
  task automatic cyc(input logic [31:0] w, input logic im, input logic dm,
                     input logic [2:0] st, input logic [4:0] cl,
                     input logic ret, input logic hl);
    instr      = w;
    imem_ready = im;
    dmem_ready = dm;
    exp_q.push_back({hl, ret, st, cl, exp_cnt});
    @(posedge CLK);
    #1;
    if (ret) exp_cnt = exp_cnt + 32'd1;
  endtask

  // Stage path as a string: digits are stages, 'f' is a stalled fetch.
  // dmem_ready is low on every MEM cycle except the last one.
  task automatic run_seq(input logic [31:0] w, input logic [4:0] cl, input string s);
    logic [2:0] st;
    logic       im;
    logic       dm;
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == "f") begin
        st = 3'd0;
        im = 1'b0;
        dm = 1'b1;
      end else begin
        st = 3'(s[i] - 8'h30);
        im = 1'b1;
        dm = !(st == 3'd3 && (i + 1) < s.len() && s[i+1] == "3");
      end
      cyc(w, im, dm, st, cl, (i == s.len() - 1), 1'b0);
    end
  endtask

  // Reset pulse; outputs are checked while reset is held low.
  task automatic do_reset();
    @(posedge CLK);
    #1;
    instr = 32'h003100B3;
    RSTn  = 1'b0;
    #1;
    exp_cnt = 32'd0;
    exp_q.push_back({1'b0, 1'b0, 3'd0, 5'd0, 32'd0});
    async_tick = ~async_tick;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RSTn       = 1'b0;
    instr      = 32'h003100B3;
    imem_ready = 1'b1;
    dmem_ready = 1'b1;
    exp_cnt    = 32'd0;
    async_tick = 1'b0;
    checks     = 0;
    errors     = 0;
    samples    = 0;

    do_reset();

    // add, lw with 3 MEM wait cycles, lui then beq
    run_seq(32'h003100B3, 5'd0,  "0124");
    run_seq(32'h0000A083, 5'd20, "01233334");
    run_seq(32'h123450B7, 5'd26, "04");
    run_seq(32'h00208063, 5'd24, "012");

    // further decodes and paths
    run_seq(32'h403100B3, 5'd1,  "0124");
    run_seq(32'h4031D0B3, 5'd9,  "0124");
    run_seq(32'h0020E063, 5'd25, "012");
    run_seq(32'h0020A023, 5'd21, "0123");
    run_seq(32'h0020A023, 5'd21, "01233");
    run_seq(32'h00000097, 5'd27, "024");
    run_seq(32'h008000EF, 5'd23, "0124");
    run_seq(32'h000080E7, 5'd22, "0124");

    // stalled fetch: inst tracks instr, illegal word does not halt while stalled
    cyc(32'h003140B3, 1'b0, 1'b1, 3'd0, 5'd4,  1'b0, 1'b0);
    cyc(32'h40109093, 1'b0, 1'b1, 3'd0, 5'd28, 1'b0, 1'b0);
    cyc(32'h0010B093, 1'b0, 1'b1, 3'd0, 5'd13, 1'b0, 1'b0);
    cyc(32'h4010D093, 1'b0, 1'b1, 3'd0, 5'd19, 1'b0, 1'b0);
    run_seq(32'h00108093, 5'd10, "ff0124");

    // asynchronous reset in EX of add: no retire, count cleared at once
    cyc(32'h003100B3, 1'b1, 1'b1, 3'd0, 5'd0, 1'b0, 1'b0);
    cyc(32'h003100B3, 1'b1, 1'b1, 3'd1, 5'd0, 1'b0, 1'b0);
    exp_q.push_back({1'b0, 1'b0, 3'd2, 5'd0, exp_cnt});
    #6;
    RSTn = 1'b0;
    #1;
    exp_cnt = 32'd0;
    exp_q.push_back({1'b0, 1'b0, 3'd0, 5'd0, 32'd0});
    async_tick = ~async_tick;
    @(posedge CLK);
    #1;
    RSTn = 1'b1;

    // 16 retires: the 4-bit counter wraps to 0 while the wide one reads 16
    for (int k = 0; k < 16; k++) run_seq(32'h123450B7, 5'd26, "04");
    run_seq(32'h003100B3, 5'd0, "0124");

    // illegal word halts; HALT holds regardless of instr until reset
    cyc(32'hFFFFFFFF, 1'b1, 1'b1, 3'd0, 5'd28, 1'b0, 1'b0);
    for (int k = 0; k < 11; k++)
      cyc((k % 2 == 0) ? 32'h003100B3 : 32'hFFFFFFFF, 1'b1, 1'b1, 3'd0, 5'd28, 1'b0, 1'b1);
    do_reset();
    run_seq(32'h003100B3, 5'd0, "0124");

    // drain the scoreboard with a bounded wait
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(posedge CLK);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, want 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
